// File: rtl/iram_download_ctrl_pkg.sv
// iram_download_ctrl_pkg: XT_BUS slave types, register offsets and download FSM states
package iram_download_ctrl_pkg;
  typedef struct packed {
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } hb_slave_t;
  typedef struct packed {
    logic ren;
    logic wen;
  } sel_t;
  localparam logic [1:0] OFF_CTRL = 2'd0;
  localparam logic [1:0] OFF_LEN = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_DATA = 2'd3;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
endpackage

// File: rtl/iram_download_ctrl_byte_word_packer.sv
// iram_download_ctrl_byte_word_packer: little-endian byte-to-word assembly with word-ready strobe
module iram_download_ctrl_byte_word_packer (
  input  logic        hb_clk,
  input  logic        rst_sync,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [1:0]  byte_idx,
  output logic        word_ready
);
  logic [23:0] sh;
  assign word = {din, sh};
  assign word_ready = en && byte_idx == 2'd3;
  always_ff @(posedge hb_clk) begin
    if (rst_sync || clr) begin
      sh <= '0;
      byte_idx <= '0;
    end else if (en) begin
      sh <= {din, sh[23:8]};
      byte_idx <= byte_idx + 2'd1;
    end
  end
endmodule

// File: rtl/iram_download_ctrl.sv
// iram_download_ctrl: XT_BUS-controlled IRAM download from a byte stream; DOWNLOAD_CHECKSUM_EN adds a stream checksum
module iram_download_ctrl
  import iram_download_ctrl_pkg::*;
#(
  parameter int IRAM_AW = 12
) (
  input  logic               hb_clk,
  input  logic               rst_sync,
  input  hb_slave_t          xt_hb,
  input  sel_t               sel,
  output logic [31:0]        rdata,
  input  logic               download_mode,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               iram_we,
  output logic [IRAM_AW-1:0] iram_addr,
  output logic [31:0]        iram_wdata
);
  state_t state, state_n;
  logic [IRAM_AW:0] len, wcnt, wcnt_n;
  logic done, err, dwr_q, idle, wr_ctrl, start, abort, go, bad_start, dwr, dwr_ok, acc, last;
  logic [31:0] pk_word, rd_mux;
  logic [1:0] byte_idx;
  logic wrdy;
  logic [7:0] csum;
  logic unused_ok;
  assign unused_ok = ^{xt_hb.raddr[31:2], xt_hb.waddr[31:2]};
  assign idle = state == IDLE || state == DONE;
  assign wr_ctrl = sel.wen && xt_hb.waddr[1:0] == OFF_CTRL;
  assign start = wr_ctrl && xt_hb.wdata[0];
  assign abort = wr_ctrl && xt_hb.wdata[1];
  assign go = start && !abort && idle && download_mode;
  assign bad_start = start && !abort && idle && !download_mode;
  assign dwr = sel.wen && xt_hb.waddr[1:0] == OFF_DATA;
  // a pending CPU pulse blocks the next one so iram_we never fires back to back
  assign dwr_ok = dwr && idle && !dwr_q;
  assign rx_ready = state == LOAD;
  assign acc = rx_valid && rx_ready;
  assign wcnt_n = wcnt + 1'b1;
  assign last = wcnt_n == len;
  assign iram_we = state == WRITE || dwr_q;
  iram_download_ctrl_byte_word_packer u_byte_word_packer (
    .hb_clk(hb_clk), .rst_sync(rst_sync), .clr(go || abort), .en(acc), .din(rx_data),
    .word(pk_word), .byte_idx(byte_idx), .word_ready(wrdy)
  );
  always_comb begin
    state_n = abort ? IDLE : go ? (len == '0 ? DONE : LOAD) : (state == LOAD && wrdy) ? WRITE :
              state == WRITE ? (last ? DONE : LOAD) : state;
    rd_mux = xt_hb.raddr[1:0] == OFF_LEN ? 32'(len) :
             xt_hb.raddr[1:0] == OFF_STATUS ? {26'd0, byte_idx, state, err, done} :
             xt_hb.raddr[1:0] == OFF_DATA ? {24'd0, csum} : '0;
  end
  always_ff @(posedge hb_clk) begin
    if (rst_sync) begin
      state <= IDLE;
      len <= '0;
      wcnt <= '0;
      iram_addr <= '0;
      iram_wdata <= '0;
      done <= 1'b0;
      err <= 1'b0;
      dwr_q <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_n;
      dwr_q <= dwr_ok;
      rdata <= sel.ren ? rd_mux : '0;
      if (sel.wen && xt_hb.waddr[1:0] == OFF_LEN) len <= xt_hb.wdata[IRAM_AW:0];
      if (state == LOAD && wrdy) iram_wdata <= pk_word;
      else if (dwr_ok) iram_wdata <= xt_hb.wdata;
      if (go) begin
        done <= len == '0;
        err <= 1'b0;
        wcnt <= '0;
        iram_addr <= '0;
      end else begin
        if (bad_start || (dwr && !dwr_ok)) err <= 1'b1;
        if (state == WRITE) wcnt <= wcnt_n;
        if (state == WRITE && last && !abort) done <= 1'b1;
        if (iram_we) iram_addr <= iram_addr + 1'b1;
      end
    end
  end
`ifdef DOWNLOAD_CHECKSUM_EN
  always_ff @(posedge hb_clk) begin
    if (rst_sync || go) csum <= '0;
    else if (acc) csum <= csum + rx_data;
  end
`else
  assign csum = '0;
`endif
endmodule

// File: tb/tb_iram_download_ctrl.sv
// tb_iram_download_ctrl: directed vectors for iram_download_ctrl (IRAM_AW=2 to exercise address wrap)
module tb_iram_download_ctrl;
  import iram_download_ctrl_pkg::*;
  localparam int AW = 2;
`ifdef DOWNLOAD_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  logic hb_clk = 0, rst_sync = 1, download_mode = 0, rx_valid = 0, rx_ready, iram_we;
  logic [7:0] rx_data = 0;
  logic [31:0] rdata, iram_wdata, rv;
  logic [AW-1:0] iram_addr;
  hb_slave_t xt_hb = '0;
  sel_t sel = '0;
  int vectors = 0, errs = 0, nw = 0, base;
  logic [31:0] wa [0:63];
  logic [31:0] wd [0:63];
  logic prev_we = 0;
  iram_download_ctrl #(.IRAM_AW(AW)) dut (
    .hb_clk(hb_clk), .rst_sync(rst_sync), .xt_hb(xt_hb), .sel(sel), .rdata(rdata),
    .download_mode(download_mode), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .iram_we(iram_we), .iram_addr(iram_addr), .iram_wdata(iram_wdata)
  );
  always #5 hb_clk = ~hb_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  always @(negedge hb_clk) begin
    if (iram_we) begin
      chk("we_gap", {31'd0, prev_we}, 32'd0);
      if (nw < 64) begin
        wa[nw] = 32'(iram_addr);
        wd[nw] = iram_wdata;
      end
      nw++;
    end
    prev_we = iram_we;
  end
  task automatic bus_wr(input logic [1:0] off, input logic [31:0] d);
    @(negedge hb_clk);
    sel.wen = 1; xt_hb.waddr = {30'd0, off}; xt_hb.wdata = d;
    @(negedge hb_clk);
    sel.wen = 0;
  endtask
  task automatic bus_rd(input logic [1:0] off, output logic [31:0] d);
    @(negedge hb_clk);
    sel.ren = 1; xt_hb.raddr = {30'd0, off};
    @(negedge hb_clk);
    sel.ren = 0;
    d = rdata;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1; rx_data = b;
    while (!rx_ready && n < 20) begin
      @(negedge hb_clk);
      n++;
    end
    if (!rx_ready) chk("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge hb_clk);
    rx_valid = 0;
  endtask
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge hb_clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
  initial begin
    idle_cycles(3);
    rst_sync = 0;
    chk("rst_rx_ready", {31'd0, rx_ready}, 0);
    chk("rst_we", {31'd0, iram_we}, 0);
    chk("rst_addr", 32'(iram_addr), 0);
    chk("rst_wdata", iram_wdata, 0);
    chk("rst_rdata", rdata, 0);
    bus_rd(OFF_STATUS, rv); chk("rst_status", rv, 0);
    idle_cycles(1); chk("rdata_no_ren", rdata, 0);
    // two-word stream download
    download_mode = 1;
    base = nw;
    bus_wr(OFF_LEN, 2);
    bus_rd(OFF_LEN, rv); chk("len_rb", rv, 2);
    bus_wr(OFF_CTRL, 1);
    bus_rd(OFF_STATUS, rv); chk("load_status", rv, 32'h4);
    foreach (wd[i]) if (i < 8) send_byte(8'(8'h11 * (i + 1)));
    idle_cycles(3);
    chk("s2_nw", nw - base, 2);
    chk("s2_a0", wa[base], 0); chk("s2_d0", wd[base], 32'h44332211);
    chk("s2_a1", wa[base+1], 1); chk("s2_d1", wd[base+1], 32'h88776655);
    bus_rd(OFF_STATUS, rv); chk("s2_status", rv, 32'hD);
    bus_rd(OFF_DATA, rv); chk("s2_csum", rv, CS ? 32'h64 : 32'h0);
    // zero-length download
    base = nw;
    bus_wr(OFF_LEN, 0);
    bus_wr(OFF_CTRL, 1);
    chk("len0_state", {30'd0, dut.state}, 3);
    bus_rd(OFF_STATUS, rv); chk("len0_status", rv, 32'hD);
    idle_cycles(3); chk("len0_nw", nw - base, 0);
    // start refused without download strap
    bus_wr(OFF_CTRL, 2);
    bus_rd(OFF_STATUS, rv); chk("abort_idle", rv, 32'h1);
    download_mode = 0;
    bus_wr(OFF_CTRL, 1);
    bus_rd(OFF_STATUS, rv); chk("nomode_status", rv, 32'h3);
    chk("nomode_rx_ready", {31'd0, rx_ready}, 0);
    // abort mid-stream
    download_mode = 1;
    base = nw;
    bus_wr(OFF_LEN, 4);
    bus_wr(OFF_CTRL, 1);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    idle_cycles(1);
    bus_rd(OFF_STATUS, rv); chk("abort_pre", rv, 32'h24);
    bus_wr(OFF_CTRL, 2);
    bus_rd(OFF_STATUS, rv); chk("abort_status", rv, 32'h0);
    bus_rd(OFF_DATA, rv); chk("abort_csum", rv, CS ? 32'h15 : 32'h0);
    idle_cycles(5);
    chk("abort_nw", nw - base, 1);
    chk("abort_a0", wa[base], 0); chk("abort_d0", wd[base], 32'h04030201);
    // CPU direct writes, then a rejected one while streaming
    bus_wr(OFF_LEN, 0);
    bus_wr(OFF_CTRL, 1);
    base = nw;
    bus_wr(OFF_DATA, 32'hDEADBEEF);
    bus_wr(OFF_DATA, 32'h00000013);
    idle_cycles(2);
    chk("cpu_nw", nw - base, 2);
    chk("cpu_a0", wa[base], 0); chk("cpu_d0", wd[base], 32'hDEADBEEF);
    chk("cpu_a1", wa[base+1], 1); chk("cpu_d1", wd[base+1], 32'h13);
    bus_wr(OFF_LEN, 1);
    bus_wr(OFF_CTRL, 1);
    base = nw;
    bus_wr(OFF_DATA, 32'h55);
    bus_rd(OFF_STATUS, rv); chk("cpu_busy_status", rv, 32'h6);
    chk("cpu_busy_nw", nw - base, 0);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i));
    idle_cycles(3);
    chk("cpu_busy_nw2", nw - base, 1);
    chk("cpu_busy_d", wd[base], 32'hA3A2A1A0);
    bus_rd(OFF_STATUS, rv); chk("cpu_busy_done", rv, 32'hF);
    // address wrap: five words into a four-word IRAM
    base = nw;
    bus_wr(OFF_LEN, 5);
    bus_wr(OFF_CTRL, 1);
    for (int k = 0; k < 5; k++) for (int j = 0; j < 4; j++) send_byte(8'(16 * k + j));
    idle_cycles(3);
    chk("wrap_nw", nw - base, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("wrap_a%0d", k), wa[base+k], 32'(k % 4));
    chk("wrap_d4", wd[base+4], 32'h43424140);
    bus_rd(OFF_STATUS, rv); chk("wrap_status", rv, 32'hD);
    // reset mid-load
    bus_wr(OFF_LEN, 2);
    bus_wr(OFF_CTRL, 1);
    send_byte(8'h77); send_byte(8'h88);
    @(negedge hb_clk); rst_sync = 1;
    @(negedge hb_clk); rst_sync = 0;
    chk("rst2_rx_ready", {31'd0, rx_ready}, 0);
    bus_rd(OFF_STATUS, rv); chk("rst2_status", rv, 0);
    bus_rd(OFF_LEN, rv); chk("rst2_len", rv, 0);
    bus_rd(OFF_DATA, rv); chk("rst2_csum", rv, 0);
    chk("rst2_addr", 32'(iram_addr), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/iram_download_ctrl.md
IRAM_DOWNLOAD_CTRL -- requirements
Module: iram_download_ctrl

Interface
REQ-001 Parameter IRAM_AW, default 12, instruction-RAM word-address width.
REQ-002 hb_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_sync  input  1  synchronous, active-high reset.
REQ-004 xt_hb  input  hb_slave_t  XT_BUS slave request (raddr, waddr, wdata); register offset = addr[1:0].
REQ-005 sel  input  sel_t  per-slave select (ren, wen).
REQ-006 rdata  output  32  registered read data.
REQ-007 download_mode  input  1  board download strap; start is permitted only when high.
REQ-008 rx_valid / rx_data  input  1 / 8  byte-stream source (UART RX).
REQ-009 rx_ready  output  1  byte accepted on a cycle with rx_valid && rx_ready.
REQ-010 iram_we / iram_addr / iram_wdata  output  1 / IRAM_AW / 32  instruction-RAM write port, one word per iram_we pulse.

Function
REQ-011 Registers: off 0 CTRL (W: bit0 start, bit1 abort); off 1 LEN (R/W, IRAM_AW+1 bits, word count); off 2 STATUS (R); off 3 DATA (W: direct CPU word write) / CHECKSUM (R).
REQ-012 STATUS = {.., byte_idx[1:0] at [5:4], state[1:0] at [3:2], err at [1], done at [0]}; done and err sticky until the next accepted start or reset.
REQ-013 FSM states IDLE, LOAD, WRITE, DONE; reset state IDLE.
REQ-014 IDLE/DONE + start && download_mode -> LOAD; word address, word counter, byte_idx cleared; done, err cleared; LEN=0 -> DONE next cycle, done=1, no write.
REQ-015 start with download_mode=0 -> state unchanged, err=1.
REQ-016 LOAD: rx_ready=1; each accepted byte shifts in little-endian (first byte -> wdata[7:0]); byte_idx increments mod 4; 4th byte -> WRITE.
REQ-017 WRITE: rx_ready=0; iram_we=1 for exactly one cycle with current address and assembled word; address and word counter increment; counter==LEN -> DONE (done=1), else LOAD.
REQ-018 Address wraps modulo 2^IRAM_AW without error.
REQ-019 abort in any state -> IDLE next cycle, partial bytes discarded, no write; abort wins over simultaneous start.
REQ-020 Arbitration: DATA write in IDLE/DONE -> iram_we pulse next cycle at current address with wdata, address increments; DATA write in LOAD/WRITE discarded, err=1 (stream owns the port).
REQ-021 CTRL start while LOAD/WRITE ignored, no flag.
REQ-022 rdata updated one cycle after sel.ren with selected register; 0 on cycles without sel.ren.
REQ-023 iram_we never asserted twice in consecutive cycles.

Reset
REQ-024 rst_sync: state IDLE, rx_ready=0, iram_we=0, iram_addr=0, iram_wdata=0, rdata=0, LEN=0, done=0, err=0, byte_idx=0, checksum=0; reset mid-LOAD discards all progress.

Configuration
REQ-025 DOWNLOAD_CHECKSUM_EN defined: 8-bit modular sum of every accepted stream byte since last start, readable at offset 3.
REQ-026 DOWNLOAD_CHECKSUM_EN undefined: no checksum logic, offset 3 reads 0.

Structure
REQ-027 Register offsets and FSM state enum live in the shared XT_BUS-side peripheral package; bus types reused from XT_BUS.
REQ-028 One sub-module, byte_word_packer (byte shift, byte_idx, word-ready strobe); FSM, arbitration and registers in the top.

Verification
REQ-029 LEN=2, start, stream 11 22 33 44 55 66 77 88 -> writes 0x44332211 @0, 0x88776655 @1; done=1; checksum 0x64.
REQ-030 LEN=0, start -> DONE next cycle, done=1, iram_we never asserted.
REQ-031 download_mode=0, start -> state IDLE, STATUS err=1, rx_ready=0.
REQ-032 LEN=4, 6 bytes, abort -> one write @0, IDLE, byte_idx=0, no further writes.
REQ-033 In IDLE, DATA writes 0xDEADBEEF, 0x00000013 -> writes @0, @1 on successive bus writes; DATA write during LOAD -> discarded, err=1.
REQ-034 Address wrap with IRAM_AW=2: LEN=5 -> fifth word written @0, done=1, err=0.
